// File: rtl/cache_pkg.sv
// Shared geometry, command encodings and controller states for the L1 data cache.
package cache_pkg;

    localparam int TAG_W      = 8;
    localparam int SET_W      = 6;
    localparam int OFF_W      = 4;
    localparam int LINE_W     = 128;
    localparam int NSETS      = 1 << SET_W;
    localparam int LINE_BYTES = LINE_W / 8;

    typedef enum logic [2:0] {
        CMD_NOP        = 3'd0,
        CMD_READ8      = 3'd1,
        CMD_READ16     = 3'd2,
        CMD_READ32     = 3'd3,
        CMD_INVALIDATE = 3'd4,
        CMD_WRITE8     = 3'd5,
        CMD_WRITE16    = 3'd6,
        CMD_WRITE32    = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA2,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESP,
        S_RESP2
    } state_e;

    function automatic logic isRead(input cmd_e c);
        return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
    endfunction

    function automatic logic isWrite(input cmd_e c);
        return (c == CMD_WRITE8) || (c == CMD_WRITE16) || (c == CMD_WRITE32);
    endfunction

endpackage

// File: rtl/cache_store.sv
// Two-way tag/valid/dirty/data arrays with per-set LRU bit.
// Combinational read by set; synchronous byte-enabled line write.
module cache_store
    import cache_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SET_W-1:0]              rdSet,
    output logic [1:0][TAG_W-1:0]         rdTag,
    output logic [1:0]                    rdValid,
    output logic [1:0]                    rdDirty,
    output logic [1:0][LINE_W-1:0]        rdData,
    output logic                          rdLru,
    input  logic                          wrEn,
    input  logic                          wrWay,
    input  logic [SET_W-1:0]              wrSet,
    input  logic [TAG_W-1:0]              wrTag,
    input  logic                          wrValid,
    input  logic                          wrDirty,
    input  logic [LINE_BYTES-1:0]         wrByteEn,
    input  logic [LINE_W-1:0]             wrData,
    input  logic                          lruWe,
    input  logic                          lruVal
);

    logic [TAG_W-1:0]      tagMem  [2][NSETS];
    logic [LINE_W-1:0]     dataMem [2][NSETS];
    logic [1:0][NSETS-1:0] validBits;
    logic [1:0][NSETS-1:0] dirtyBits;
    logic [NSETS-1:0]      lruBits;

    always_comb begin
        rdTag[0]   = tagMem[0][rdSet];
        rdTag[1]   = tagMem[1][rdSet];
        rdData[0]  = dataMem[0][rdSet];
        rdData[1]  = dataMem[1][rdSet];
        rdValid    = {validBits[1][rdSet], validBits[0][rdSet]};
        rdDirty    = {dirtyBits[1][rdSet], dirtyBits[0][rdSet]};
        rdLru      = lruBits[rdSet];
    end

    // Line contents and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrWay][wrSet] <= wrTag;
            for (int unsigned b = 0; b < LINE_BYTES; b++) begin
                if (wrByteEn[b])
                    dataMem[wrWay][wrSet][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validBits <= '0;
            dirtyBits <= '0;
            lruBits   <= '0;
        end else begin
            if (wrEn) begin
                validBits[wrWay][wrSet] <= wrValid;
                dirtyBits[wrWay][wrSet] <= wrDirty;
            end
            if (lruWe)
                lruBits[wrSet] <= lruVal;
        end
    end

endmodule

// File: rtl/l1_cache.sv
// 2-way set-associative write-back, write-allocate L1 data cache:
// CPU command FSM, request latches, hit/victim selection and memory line port.
module l1_cache #(
    parameter int TAG_W  = 8,
    parameter int SET_W  = 6,
    parameter int OFF_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    cpu_cmd,
    input  logic [TAG_W+SET_W+OFF_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_resp,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [TAG_W+SET_W-1:0]        mem_addr,
    output logic [cache_pkg::LINE_W-1:0]  mem_wdata,
    input  logic [cache_pkg::LINE_W-1:0]  mem_rdata,
    input  logic                          mem_ack
);

    import cache_pkg::*;

    localparam int ADDR_W = TAG_W + SET_W + OFF_W;

    state_e                 state, nextState;
    cmd_e                   inCmd, reqCmd;
    logic [ADDR_W-1:0]      reqAddr;
    logic [2*DATA_W-1:0]    reqWdata, respData, respNext, readWord;
    logic                   victimWay;

    logic [TAG_W-1:0]       reqTag;
    logic [SET_W-1:0]       reqSet;
    logic [OFF_W-1:0]       reqOff;

    logic [1:0][TAG_W-1:0]  rdTag;
    logic [1:0]             rdValid, rdDirty;
    logic [1:0][LINE_W-1:0] rdData;
    logic                   rdLru;

    logic                   wrEn, wrWay, wrValid, wrDirty, lruWe, lruVal;
    logic [TAG_W-1:0]       wrTag;
    logic [LINE_BYTES-1:0]  wrByteEn, accByteEn;
    logic [LINE_W-1:0]      wrData, accLine;

    logic [1:0]             hit;
    logic                   hitAny, hitWay, missVictim;
    logic [OFF_W-1:0]       accBase;
    logic [3:0]             accMask;

    assign inCmd  = cmd_e'(cpu_cmd);
    assign reqTag = reqAddr[ADDR_W-1 -: TAG_W];
    assign reqSet = reqAddr[OFF_W +: SET_W];
    assign reqOff = reqAddr[OFF_W-1:0];

    cache_store store (
        .clk      (clk),
        .reset    (reset),
        .rdSet    (reqSet),
        .rdTag    (rdTag),
        .rdValid  (rdValid),
        .rdDirty  (rdDirty),
        .rdData   (rdData),
        .rdLru    (rdLru),
        .wrEn     (wrEn),
        .wrWay    (wrWay),
        .wrSet    (reqSet),
        .wrTag    (wrTag),
        .wrValid  (wrValid),
        .wrDirty  (wrDirty),
        .wrByteEn (wrByteEn),
        .wrData   (wrData),
        .lruWe    (lruWe),
        .lruVal   (lruVal)
    );

    // Victim: first invalid way (way 0 first), otherwise the LRU way.
    assign hit[0]     = rdValid[0] && (rdTag[0] == reqTag);
    assign hit[1]     = rdValid[1] && (rdTag[1] == reqTag);
    assign hitAny     = |hit;
    assign hitWay     = hit[1];
    assign missVictim = !rdValid[0] ? 1'b0 : (!rdValid[1] ? 1'b1 : rdLru);

    always_comb begin
        accBase = {reqOff[OFF_W-1:2], 2'b00};
        accMask = 4'b1111;
        case (reqCmd)
            CMD_READ8, CMD_WRITE8: begin
                accBase = reqOff;
                accMask = 4'b0001;
            end
            CMD_READ16, CMD_WRITE16: begin
                accBase = {reqOff[OFF_W-1:1], 1'b0};
                accMask = 4'b0011;
            end
            default: ;
        endcase
    end

    assign accByteEn = LINE_BYTES'(accMask) << accBase;
    assign accLine   = LINE_W'(reqWdata) << (8 * accBase);
    assign readWord  = (2*DATA_W)'(rdData[hitWay] >> (8 * accBase));

    always_comb begin
        respNext = readWord;
        case (reqCmd)
            CMD_READ8:  respNext = {{(2*DATA_W-8){1'b0}}, readWord[7:0]};
            CMD_READ16: respNext = {{DATA_W{1'b0}}, readWord[DATA_W-1:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:
                if (inCmd != CMD_NOP)
                    nextState = (inCmd == CMD_WRITE32) ? S_WDATA2 : S_LOOKUP;
            S_WDATA2:
                nextState = S_LOOKUP;
            S_LOOKUP:
                if (reqCmd == CMD_INVALIDATE)
                    nextState = (hitAny && rdDirty[hitWay]) ? S_WRITEBACK : S_RESP;
                else if (hitAny)
                    nextState = S_RESP;
                else if (rdValid[missVictim] && rdDirty[missVictim])
                    nextState = S_WRITEBACK;
                else
                    nextState = S_FILL;
            S_WRITEBACK:
                if (mem_ack)
                    nextState = (reqCmd == CMD_INVALIDATE) ? S_RESP : S_FILL;
            S_FILL:
                if (mem_ack)
                    nextState = S_LOOKUP;
            S_RESP:
                nextState = (reqCmd == CMD_READ32) ? S_RESP2 : S_IDLE;
            S_RESP2:
                nextState = S_IDLE;
            default:
                nextState = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state == S_IDLE);
        cpu_resp  = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_RESP: begin
                cpu_resp = 1'b1;
                if (isRead(reqCmd))
                    cpu_rdata = respData[DATA_W-1:0];
            end
            S_RESP2: begin
                cpu_resp  = 1'b1;
                cpu_rdata = respData[2*DATA_W-1:DATA_W];
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rdTag[victimWay], reqSet};
                mem_wdata = rdData[victimWay];
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {reqTag, reqSet};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqCmd    <= CMD_NOP;
            reqAddr   <= '0;
            reqWdata  <= '0;
            respData  <= '0;
            victimWay <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (inCmd != CMD_NOP) begin
                        reqCmd   <= inCmd;
                        reqAddr  <= cpu_addr;
                        reqWdata <= {{DATA_W{1'b0}}, cpu_wdata};
                    end
                S_WDATA2:
                    reqWdata[2*DATA_W-1:DATA_W] <= cpu_wdata;
                S_LOOKUP: begin
                    if (reqCmd == CMD_INVALIDATE)
                        victimWay <= hitWay;
                    else if (!hitAny)
                        victimWay <= missVictim;
                    if (hitAny && isRead(reqCmd))
                        respData <= respNext;
                end
                default: ;
            endcase
        end
    end

    // Writeback of a miss victim only clears dirty; the following fill overwrites the way.
    always_comb begin
        wrEn     = 1'b0;
        wrWay    = hitWay;
        wrTag    = reqTag;
        wrValid  = 1'b0;
        wrDirty  = 1'b0;
        wrByteEn = '0;
        wrData   = accLine;
        lruWe    = 1'b0;
        lruVal   = 1'b0;
        case (state)
            S_LOOKUP:
                if (reqCmd == CMD_INVALIDATE) begin
                    if (hitAny && !rdDirty[hitWay]) begin
                        wrEn   = 1'b1;
                        wrTag  = rdTag[hitWay];
                        lruWe  = 1'b1;
                        lruVal = hitWay;
                    end
                end else if (hitAny) begin
                    lruWe  = 1'b1;
                    lruVal = !hitWay;
                    if (isWrite(reqCmd)) begin
                        wrEn     = 1'b1;
                        wrValid  = 1'b1;
                        wrDirty  = 1'b1;
                        wrByteEn = accByteEn;
                    end
                end
            S_WRITEBACK:
                if (mem_ack) begin
                    wrEn    = 1'b1;
                    wrWay   = victimWay;
                    wrTag   = rdTag[victimWay];
                    wrValid = (reqCmd != CMD_INVALIDATE);
                    if (reqCmd == CMD_INVALIDATE) begin
                        lruWe  = 1'b1;
                        lruVal = victimWay;
                    end
                end
            S_FILL:
                if (mem_ack) begin
                    wrEn     = 1'b1;
                    wrWay    = victimWay;
                    wrValid  = 1'b1;
                    wrByteEn = '1;
                    wrData   = mem_rdata;
                end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: a small line-memory responder plus hand-computed expectations.
module tb_l1_cache;

    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   cpu_cmd;
    logic [17:0]  cpu_addr;
    logic [15:0]  cpu_wdata;
    logic         cpu_ready, cpu_resp;
    logic [15:0]  cpu_rdata;
    logic         mem_req, mem_we, mem_ack;
    logic [13:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    l1_cache #(.TAG_W(8), .SET_W(6), .OFF_W(4), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_cmd   (cpu_cmd),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_resp  (cpu_resp),
        .cpu_rdata (cpu_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int unsigned  nChecks = 0;
    int unsigned  nPass   = 0;

    int unsigned  nEv, nResp, respLat;
    logic         evWe   [4];
    logic [13:0]  evAddr [4];
    logic [127:0] evData [4];
    logic [15:0]  rd0, rd1;
    bit           runDone;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] mkLine(input logic [7:0] base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++)
            l[8*k +: 8] = base + 8'(k);
        return l;
    endfunction

    // Issue one command and service memory (ack on the 2nd cycle of each request) until IDLE.
    task automatic runCmd(input logic [2:0] cmd, input logic [17:0] addr, input logic [15:0] wd,
                          input logic [15:0] wd2, input logic [7:0] fillBase);
        int unsigned cyc;
        int unsigned reqCycles;
        nEv = 0; nResp = 0; respLat = 0; rd0 = '0; rd1 = '0; reqCycles = 0; runDone = 0;
        cpu_cmd = cmd; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_cmd = 3'd0; cpu_wdata = wd2;
        cyc = 1;
        while (!runDone && cyc < 60) begin
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (cpu_resp) begin
                if (nResp == 0) begin rd0 = cpu_rdata; respLat = cyc; end
                else rd1 = cpu_rdata;
                nResp++;
            end
            if (mem_req) begin
                if (reqCycles == 0 && nEv < 4) begin
                    evWe[nEv] = mem_we; evAddr[nEv] = mem_addr; evData[nEv] = mem_wdata;
                    nEv++;
                end
                reqCycles++;
                if (reqCycles == 2) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_we ? '0 : mkLine(fillBase);
                    reqCycles = 0;
                end
            end
            if (cpu_ready) runDone = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkEq("cmd completes", runDone, 1);
    endtask

    initial begin
        int unsigned waitCnt;
        reset = 1'b1; cpu_cmd = '0; cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst ready", cpu_ready, 1);
        checkEq("rst resp", cpu_resp, 0);
        checkEq("rst rdata", cpu_rdata, 0);
        checkEq("rst mem_req", mem_req, 0);
        checkEq("rst mem_addr", mem_addr, 0);
        checkEq("rst mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Cold miss then hit on tag 1, set 0
        runCmd(CMD_READ16, 18'h00404, 16'h0, 16'h0, 8'h00);
        checkEq("cold nEv", nEv, 1);
        checkEq("cold fill we", evWe[0], 0);
        checkEq("cold fill addr", evAddr[0], 14'h040);
        checkEq("cold rdata", rd0, 16'h0504);
        checkEq("cold nResp", nResp, 1);
        runCmd(CMD_READ16, 18'h00404, 16'h0, 16'h0, 8'h00);
        checkEq("hit nEv", nEv, 0);
        checkEq("hit rdata", rd0, 16'h0504);
        checkEq("hit latency", respLat, 2);

        runCmd(CMD_WRITE8, 18'h00405, 16'h00AA, 16'h0, 8'h00);
        checkEq("wr8 nEv", nEv, 0);
        checkEq("wr8 rdata", rd0, 16'h0000);
        checkEq("wr8 latency", respLat, 2);
        runCmd(CMD_READ32, 18'h00404, 16'h0, 16'h0, 8'h00);
        checkEq("rd32 nResp", nResp, 2);
        checkEq("rd32 low", rd0, 16'hAA04);
        checkEq("rd32 high", rd1, 16'h0706);

        // LRU victim selection in set 0
        runCmd(CMD_READ8, 18'h00800, 16'h0, 16'h0, 8'h20);
        checkEq("tag2 fill addr", evAddr[0], 14'h080);
        checkEq("tag2 rdata", rd0, 16'h0020);
        runCmd(CMD_READ8, 18'h00400, 16'h0, 16'h0, 8'h00);
        checkEq("tag1 touch nEv", nEv, 0);
        checkEq("tag1 touch rdata", rd0, 16'h0000);
        runCmd(CMD_READ8, 18'h00C00, 16'h0, 16'h0, 8'h40);
        checkEq("tag3 nEv", nEv, 1);
        checkEq("tag3 fill we", evWe[0], 0);
        checkEq("tag3 fill addr", evAddr[0], 14'h0C0);
        checkEq("tag3 rdata", rd0, 16'h0040);

        // Dirty eviction of tag 1
        runCmd(CMD_WRITE16, 18'h00403, 16'hBEEF, 16'h0, 8'h00);
        checkEq("wr16 nEv", nEv, 0);
        runCmd(CMD_READ8, 18'h00C01, 16'h0, 16'h0, 8'h00);
        checkEq("tag3 touch rdata", rd0, 16'h0041);
        runCmd(CMD_READ16, 18'h01000, 16'h0, 16'h0, 8'h60);
        checkEq("evict nEv", nEv, 2);
        checkEq("evict wb we", evWe[0], 1);
        checkEq("evict wb addr", evAddr[0], 14'h040);
        checkEq("evict wb data", evData[0], 128'h0f0e0d0c0b0a0908_0706AA04BEEF0100);
        checkEq("evict fill we", evWe[1], 0);
        checkEq("evict fill addr", evAddr[1], 14'h100);
        checkEq("evict rdata", rd0, 16'h6160);

        // Invalidate dirty and absent lines
        runCmd(CMD_WRITE32, 18'h00C0B, 16'h1234, 16'h5678, 8'h00);
        checkEq("wr32 nEv", nEv, 0);
        checkEq("wr32 latency", respLat, 3);
        runCmd(CMD_INVALIDATE, 18'h00C00, 16'h0, 16'h0, 8'h00);
        checkEq("inv nEv", nEv, 1);
        checkEq("inv wb we", evWe[0], 1);
        checkEq("inv wb addr", evAddr[0], 14'h0C0);
        checkEq("inv wb data", evData[0], 128'h4F4E4D4C_56781234_47464544_43424140);
        checkEq("inv rdata", rd0, 16'h0000);
        checkEq("inv nResp", nResp, 1);
        runCmd(CMD_READ8, 18'h00C00, 16'h0, 16'h0, 8'h80);
        checkEq("post inv nEv", nEv, 1);
        checkEq("post inv fill addr", evAddr[0], 14'h0C0);
        checkEq("post inv rdata", rd0, 16'h0080);
        runCmd(CMD_INVALIDATE, 18'h03F00, 16'h0, 16'h0, 8'h00);
        checkEq("inv absent nEv", nEv, 0);
        checkEq("inv absent nResp", nResp, 1);
        checkEq("inv absent latency", respLat, 2);

        // Reset while a fill is outstanding
        cpu_cmd = CMD_READ8; cpu_addr = 18'h02040;
        @(posedge clk); #1;
        cpu_cmd = 3'd0;
        waitCnt = 0;
        while (!mem_req && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkEq("pre-reset mem_req", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        checkEq("async mem_req drop", mem_req, 0);
        checkEq("async ready", cpu_ready, 1);
        checkEq("async mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        runCmd(CMD_READ8, 18'h02040, 16'h0, 16'h0, 8'hC0);
        checkEq("after rst nEv", nEv, 1);
        checkEq("after rst fill addr", evAddr[0], 14'h204);
        checkEq("after rst rdata", rd0, 16'h00C0);
        runCmd(CMD_READ8, 18'h01000, 16'h0, 16'h0, 8'hE0);
        checkEq("rst wiped nEv", nEv, 1);
        checkEq("rst wiped rdata", rd0, 16'h00E0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- 2-way set-associative, write-back, write-allocate data cache between the CPU command bus and a line-wide memory port.
- 18-bit byte address: tag = addr[17:10] (8 bits), set = addr[9:4] (64 sets), offset = addr[3:0] (16-byte lines).
- The CPU side carries 3-bit commands and 16-bit data; 32-bit accesses use two 16-bit beats.
- The memory side transfers whole 128-bit lines with a req/ack handshake.

Parameters:
- TAG_W, 8, tag bits
- SET_W, 6, set-index bits (64 sets)
- OFF_W, 4, byte offset bits (16-byte line)
- DATA_W, 16, CPU data beat width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cpu_cmd  in  3  0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE, 5 WRITE8, 6 WRITE16, 7 WRITE32
- cpu_addr  in  18  byte address, sampled with the command
- cpu_wdata  in  16  write data: low half with the command; high half of WRITE32 on the next cycle
- cpu_ready  out  1  high exactly in IDLE; a command is accepted only when it is high
- cpu_resp  out  1  one-cycle response strobe per beat
- cpu_rdata  out  16  read data, valid while cpu_resp is high, otherwise 0
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  14  line address {tag,set}
- mem_wdata  out  128  writeback line
- mem_rdata  in  128  fill line, sampled in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (async):
  - All valid, dirty and LRU bits are 0; line data contents are don't-care.
  - State = IDLE; cpu_resp, cpu_rdata, mem_req, mem_we, mem_addr and mem_wdata are 0; cpu_ready = 1.
  - Reset mid-operation aborts immediately and drops mem_req. A partially completed fill or writeback leaves no installed line.
- Byte order is little-endian: byte k of a line = line[8k+7:8k]. Unused low address bits are ignored (READ16/WRITE16 ignore addr[0]; 32-bit ops ignore addr[1:0]).
- States: IDLE, WDATA2, LOOKUP, WRITEBACK, FILL, RESP, RESP2.
- IDLE:
  - On cpu_cmd != 0, latch cmd, addr and cpu_wdata.
  - WRITE32 goes to WDATA2, which latches the high half next cycle, then LOOKUP.
  - All other commands go directly to LOOKUP.
- LOOKUP compares the tag against both valid ways of the set.
  - Hit:
    - Reads capture the data.
    - Writes merge the bytes and set dirty.
    - The hit way becomes MRU (LRU bit points to the other way).
    - Next state RESP.
  - Miss on read/write:
    - Victim = first invalid way (way 0 preferred), else the LRU way.
    - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
  - INVALIDATE:
    - Hit + dirty: WRITEBACK, then clear valid and dirty, then RESP.
    - Hit + clean: clear valid, then RESP.
    - Miss: RESP, no state change.
    - LRU is set to point at the invalidated way.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,set}, mem_wdata=victim line, held stable until mem_ack. Next state is FILL (or RESP for INVALIDATE).
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag,set}, held until mem_ack.
  - In the mem_ack cycle, install mem_rdata with valid=1, dirty=0 and the new tag.
  - Return to LOOKUP, which now hits.
- RESP: cpu_resp=1 for one cycle.
  - READ8: rdata = zero-extended byte.
  - READ16: the halfword.
  - READ32: the low half, followed by RESP2 (high half, cpu_resp=1 again).
  - Writes and INVALIDATE: rdata = 0.
  - Then IDLE.
- Hit latency: command accepted in cycle T, cpu_resp in T+2 (T+3 for WRITE32). Miss adds the cycles spent waiting for mem_ack.
- cpu_cmd is ignored whenever cpu_ready = 0.
- mem_ack outside WRITEBACK/FILL is ignored.

Decomposition:
- Package cache_pkg holds:
  - command encodings as an enum (CMD_NOP … CMD_WRITE32)
  - TAG_W, SET_W, OFF_W, LINE_W = 128
  - the state enum
- One sub-module, cache_store: per-way tag, valid, dirty and data arrays plus per-set LRU bits.
  - Combinational read by set.
  - Synchronous write with byte-enable line merge.
- l1_cache holds the FSM, request latches and the hit/victim logic.

Test Plan:
- Reset, then READ16 addr 0x00404 (cold miss) -> FILL with mem_addr 0x0040; ack with mem_rdata byte k = k -> cpu_resp with rdata 0x0504. Repeat READ16 -> hit, resp at T+2, no mem_req.
- WRITE8 addr 0x00405 data 0x00AA (hit) -> subsequent READ32 addr 0x00404 returns 0xAA04, then 0x0706 on RESP2.
- Fill tags 0x01 and 0x02 into set 0, access tag 0x01, then READ8 tag 0x03 set 0 -> victim is tag 0x02's way; clean, so no writeback, fill only.
- Dirty the tag 0x01 line via WRITE16, then force its eviction -> WRITEBACK with mem_we=1, mem_addr {0x01,set 0}, merged data, before the FILL.
- INVALIDATE on a dirty line -> writeback, then valid cleared; next READ8 misses. INVALIDATE on an absent line -> cpu_resp with no mem_req.
- Assert reset during a FILL before mem_ack -> mem_req drops asynchronously, cpu_ready=1, and the line stays invalid (next read misses).
